decode_exec_unit: RTL and testbench

DECODE_EXEC_UNIT -- requirements
Module: decode_exec_unit

---
 rtl/decode_exec_unit.sv | 215 +++++++++++++++++++++
 tb/tb_decode_exec_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_exec_unit.sv
// decode_exec_unit: single-stage RV32 subset decoder and ALU with a
// registered execute bundle.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset, clears all ex_*
//   nop             stall; ex_* registers hold while high
//   instr[31:0]     instruction in decode
//   pc[31:0]        address of instr
//   rs1_data[31:0]  register-file value for instr's rs1
//   rs2_data[31:0]  register-file value for instr's rs2
//   opcode/funct3/funct7/rs1/rs2/rd  combinational instruction fields
//   ex_result       registered ALU result
//   ex_link         registered pc+4 (used by JAL)
//   ex_rd/ex_opcode/ex_alusel        registered copies
//   ex_load/ex_store/ex_jump/ex_branch_taken/ex_reg_write  registered flags
module decode_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        nop,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] ex_result,
  output logic [31:0] ex_link,
  output logic [4:0]  ex_rd,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_alusel,
  output logic        ex_load,
  output logic        ex_store,
  output logic        ex_jump,
  output logic        ex_branch_taken,
  output logic        ex_reg_write
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  logic        w_is_r;
  logic        w_is_i;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_is_br;
  logic        w_is_jal;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [2:0]  w_alusel;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [4:0]  w_shamt;
  logic [31:0] w_result;
  logic        w_reg_write;
  logic        w_taken;

  logic [31:0] r_result;
  logic [31:0] r_link;
  logic [4:0]  r_rd;
  logic [6:0]  r_opcode;
  logic [2:0]  r_alusel;
  logic        r_load;
  logic        r_store;
  logic        r_jump;
  logic        r_taken;
  logic        r_reg_write;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign w_is_r   = (opcode == OP_R);
  assign w_is_i   = (opcode == OP_I);
  assign w_is_ld  = (opcode == OP_LD);
  assign w_is_st  = (opcode == OP_ST);
  assign w_is_br  = (opcode == OP_BR);
  assign w_is_jal = (opcode == OP_JAL);

  // Branch and JAL offsets are stored without bit 0; append it here.
  assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
  assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

  // instr[30] selects SUB only for R-type; for I-ALU it is immediate data.
  always_comb begin
    w_alusel = ALU_ADD;
    if (w_is_r || w_is_i) begin
      unique case (funct3)
        3'b000:  w_alusel = (w_is_r && instr[30]) ? ALU_SUB : ALU_ADD;
        3'b111:  w_alusel = ALU_AND;
        3'b110:  w_alusel = ALU_OR;
        3'b100:  w_alusel = ALU_XOR;
        3'b001:  w_alusel = ALU_SLL;
        3'b101:  w_alusel = instr[30] ? ALU_SRA : ALU_SRL;
        default: w_alusel = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    unique case (1'b1)
      w_is_r: begin
        w_op1 = rs1_data;
        w_op2 = rs2_data;
      end
      w_is_i, w_is_ld: begin
        w_op1 = rs1_data;
        w_op2 = w_imm_i;
      end
      w_is_st: begin
        w_op1 = rs1_data;
        w_op2 = w_imm_s;
      end
      w_is_br: begin
        w_op1 = pc;
        w_op2 = w_imm_b;
      end
      w_is_jal: begin
        w_op1 = pc;
        w_op2 = w_imm_j;
      end
      default: begin
        w_op1 = '0;
        w_op2 = '0;
      end
    endcase
  end

  assign w_shamt = w_op2[4:0];

  always_comb begin
    w_result = '0;
    unique case (w_alusel)
      ALU_ADD: w_result = w_op1 + w_op2;
      ALU_SUB: w_result = w_op1 - w_op2;
      ALU_AND: w_result = w_op1 & w_op2;
      ALU_OR:  w_result = w_op1 | w_op2;
      ALU_XOR: w_result = w_op1 ^ w_op2;
      ALU_SLL: w_result = w_op1 << w_shamt;
      ALU_SRL: w_result = w_op1 >> w_shamt;
      ALU_SRA: w_result = $unsigned($signed(w_op1) >>> w_shamt);
      default: w_result = '0;
    endcase
  end

  assign w_taken     = w_is_br && (rs1_data == rs2_data);
  assign w_reg_write = (w_is_r || w_is_i || w_is_ld || w_is_jal)
                       && (rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= '0;
      r_link      <= '0;
      r_rd        <= '0;
      r_opcode    <= '0;
      r_alusel    <= '0;
      r_load      <= 1'b0;
      r_store     <= 1'b0;
      r_jump      <= 1'b0;
      r_taken     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (!nop) begin
      r_result    <= w_result;
      r_link      <= pc + 32'd4;
      r_rd        <= rd;
      r_opcode    <= opcode;
      r_alusel    <= w_alusel;
      r_load      <= w_is_ld;
      r_store     <= w_is_st;
      r_jump      <= w_is_jal;
      r_taken     <= w_taken;
      r_reg_write <= w_reg_write;
    end
  end

  assign ex_result       = r_result;
  assign ex_link         = r_link;
  assign ex_rd           = r_rd;
  assign ex_opcode       = r_opcode;
  assign ex_alusel       = r_alusel;
  assign ex_load         = r_load;
  assign ex_store        = r_store;
  assign ex_jump         = r_jump;
  assign ex_branch_taken = r_taken;
  assign ex_reg_write    = r_reg_write;

endmodule

// File: tb/tb_decode_exec_unit.sv
// tb_decode_exec_unit: directed vectors for decode_exec_unit with
// hand-computed expectations.
module tb_decode_exec_unit;

  logic        clk;
  logic        rst;
  logic        nop;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] ex_result;
  logic [31:0] ex_link;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_alusel;
  logic        ex_load;
  logic        ex_store;
  logic        ex_jump;
  logic        ex_branch_taken;
  logic        ex_reg_write;

  int n_chk;
  int n_err;

  decode_exec_unit dut (
    .clk(clk),
    .rst(rst),
    .nop(nop),
    .instr(instr),
    .pc(pc),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .opcode(opcode),
    .funct3(funct3),
    .funct7(funct7),
    .rs1(rs1),
    .rs2(rs2),
    .rd(rd),
    .ex_result(ex_result),
    .ex_link(ex_link),
    .ex_rd(ex_rd),
    .ex_opcode(ex_opcode),
    .ex_alusel(ex_alusel),
    .ex_load(ex_load),
    .ex_store(ex_store),
    .ex_jump(ex_jump),
    .ex_branch_taken(ex_branch_taken),
    .ex_reg_write(ex_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packed {load,store,jump,taken,reg_write}
  function automatic logic [31:0] flags();
    return {27'd0, ex_load, ex_store, ex_jump,
            ex_branch_taken, ex_reg_write};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    instr    = i;
    pc       = p;
    rs1_data = a;
    rs2_data = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex(input string tag, input logic [31:0] res,
                        input logic [2:0] sel, input logic [4:0] fl);
    check({tag, ".res"}, ex_result, res);
    check({tag, ".sel"}, {29'd0, ex_alusel}, {29'd0, sel});
    check({tag, ".flg"}, flags(), {27'd0, fl});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    nop   = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    #2;
    check("rst.res", ex_result, 32'h0);
    check("rst.link", ex_link, 32'h0);
    check("rst.flg", flags(), 32'h0);
    check("rst.rdop", {20'd0, ex_rd, ex_opcode}, 32'h0);
    step();
    check("rst.hold", ex_result, 32'h0);
    rst = 1'b0;

    // add x3,x1,x2
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    #1;
    check("f.add", {5'd0, funct7, rs2, rs1, funct3, rd, opcode},
          {5'd0, 7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33});
    step();
    chk_ex("add", 32'd12, 3'b000, 5'b00001);
    check("add.rd", {27'd0, ex_rd}, 32'd3);
    check("add.op", {25'd0, ex_opcode}, 32'h33);

    drive(32'h402081B3, 32'h0, 32'd5, 32'd7);
    step();
    chk_ex("sub", 32'hFFFFFFFE, 3'b001, 5'b00001);

    // addi x1,x0,-1
    drive(32'hFFF00093, 32'h0, 32'd0, 32'd0);
    #1;
    check("f.addi.rd", {27'd0, rd}, 32'd1);
    check("f.addi.rs1", {27'd0, rs1}, 32'd0);
    step();
    chk_ex("addi", 32'hFFFFFFFF, 3'b000, 5'b00001);

    // addi x1,x1,0x400: instr[30] set but I-type stays ADD
    drive(32'h40008093, 32'h0, 32'h10, 32'h0);
    step();
    chk_ex("addi30", 32'h410, 3'b000, 5'b00001);

    // sw x2,8(x1)
    drive(32'h0020A423, 32'h0, 32'h100, 32'h55);
    step();
    chk_ex("sw", 32'h108, 3'b000, 5'b01000);

    // lw x5,-4(x1)
    drive(32'hFFC0A283, 32'h0, 32'h100, 32'h0);
    step();
    chk_ex("lw", 32'hFC, 3'b000, 5'b10001);

    // beq +8 taken / not taken
    drive(32'h00208463, 32'h40, 32'd9, 32'd9);
    step();
    chk_ex("beq.t", 32'h48, 3'b000, 5'b00010);
    drive(32'h00208463, 32'h40, 32'd9, 32'd10);
    step();
    chk_ex("beq.n", 32'h48, 3'b000, 5'b00000);

    // jal x1,+16
    drive(32'h010000EF, 32'h20, 32'd3, 32'd4);
    step();
    chk_ex("jal", 32'h30, 3'b000, 5'b00101);
    check("jal.link", ex_link, 32'h24);

    // xor / srl / sra / slli / srai
    drive(32'h0020C1B3, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00);
    step();
    chk_ex("xor", 32'h0FF00FF0, 3'b100, 5'b00001);
    drive(32'h0020D1B3, 32'h0, 32'h80000000, 32'd4);
    step();
    chk_ex("srl", 32'h08000000, 3'b110, 5'b00001);
    drive(32'h4020D1B3, 32'h0, 32'h80000000, 32'd4);
    step();
    chk_ex("sra", 32'hF8000000, 3'b111, 5'b00001);
    drive(32'h00309093, 32'h0, 32'd1, 32'd0);
    step();
    chk_ex("slli", 32'd8, 3'b101, 5'b00001);
    drive(32'h4030D093, 32'h0, 32'h80000000, 32'd0);
    step();
    chk_ex("srai", 32'hF0000000, 3'b111, 5'b00001);

    // add with rd=x0: no write
    drive(32'h00208033, 32'h0, 32'd5, 32'd7);
    step();
    chk_ex("add.x0", 32'd12, 3'b000, 5'b00000);

    // unsupported (LUI)
    drive(32'h00000037, 32'h0, 32'd5, 32'd7);
    step();
    chk_ex("unsup", 32'h0, 3'b000, 5'b00000);

    // stall holds for two edges, fields keep tracking
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    step();
    chk_ex("pre.nop", 32'd12, 3'b000, 5'b00001);
    nop = 1'b1;
    drive(32'h4020D1B3, 32'h80, 32'h80000000, 32'd4);
    #1;
    check("nop.f3", {29'd0, funct3}, 32'd5);
    step();
    chk_ex("nop1", 32'd12, 3'b000, 5'b00001);
    drive(32'h0020A423, 32'h90, 32'h100, 32'd1);
    step();
    chk_ex("nop2", 32'd12, 3'b000, 5'b00001);
    check("nop2.rd", {27'd0, ex_rd}, 32'd3);

    // async reset mid-cycle, dominating nop
    #2;
    rst = 1'b1;
    #1;
    check("arst.res", ex_result, 32'h0);
    check("arst.link", ex_link, 32'h0);
    check("arst.flg", flags(), 32'h0);
    check("arst.sel", {20'd0, ex_rd, ex_alusel, 4'd0}, 32'h0);
    step();
    check("arst.hold", ex_result, 32'h0);
    rst = 1'b0;
    nop = 1'b0;
    drive(32'h010000EF, 32'h20, 32'd0, 32'd0);
    step();
    chk_ex("post.rst", 32'h30, 3'b000, 5'b00101);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
